// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err strobes.
// Stop sample lands HALF + 9*(N+1) + 1 clocks after START entry; no back-pressure, a missed valid loses the byte.
module uart_rx #(
    parameter int N    = 10416,
    parameter int HALF = (N + 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] d_in,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    d_in_q;
    logic          valid_q;
    logic          frame_err_q;
    logic [1:0]    sync_q;
    logic          rx_p_q;

    logic          rx_s;
    logic          fall;
    logic [7:0]    shift_d;

    assign rx_s    = sync_q[1];
    assign fall    = rx_p_q & ~rx_s;
    // LSB arrives first, so each new bit enters at the top and walks down.
    assign shift_d = {rx_s, shift_q[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            d_in_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            sync_q      <= 2'b11;
            rx_p_q      <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], rx};
            rx_p_q      <= rx_s;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        shift_q <= shift_d;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        // A low stop bit (or break) drops the byte but keeps the last good one.
                        if (rx_s) begin
                            d_in_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign d_in      = d_in_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
